// File: rtl/mem_request_sequencer_if.sv
// ----------------------------------------------------------------------------
// mem_request_sequencer_if
// Bundles the three handshake ports of the memory request sequencer:
//   - core request port   (req_*, valid/ready)
//   - core response port  (rsp_*, valid/ready)
//   - memory command port (mem_*, en/ready)
// The slave modport is the sequencer's view. The master modport is the
// surroundings' view: the core plus the memory unit.
// ----------------------------------------------------------------------------
interface mem_request_sequencer_if #(
   parameter int WORDSIZE          = 8,
   parameter int MEMORY_ADDR_WIDTH = 8
);

   // Core request port
   logic                         req_valid;
   logic                         req_ready;
   logic                         req_op;
   logic [MEMORY_ADDR_WIDTH-1:0] req_addr;
   logic [WORDSIZE-1:0]          req_wdata;

   // Core response port
   logic                         rsp_valid;
   logic                         rsp_ready;
   logic                         rsp_op;
   logic [WORDSIZE-1:0]          rsp_rdata;
   logic                         rsp_err;

   // Memory unit command port
   logic                         mem_en;
   logic                         mem_op;
   logic [MEMORY_ADDR_WIDTH-1:0] mem_addr;
   logic [WORDSIZE-1:0]          mem_datain;
   logic [WORDSIZE-1:0]          mem_dataout;
   logic                         mem_ready;

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata,
      output req_ready,
      output rsp_valid, rsp_op, rsp_rdata, rsp_err,
      input  rsp_ready,
      output mem_en, mem_op, mem_addr, mem_datain,
      input  mem_dataout, mem_ready
   );

   modport master (
      output req_valid, req_op, req_addr, req_wdata,
      input  req_ready,
      input  rsp_valid, rsp_op, rsp_rdata, rsp_err,
      output rsp_ready,
      input  mem_en, mem_op, mem_addr, mem_datain,
      output mem_dataout, mem_ready
   );

endinterface

// File: rtl/mem_request_sequencer.sv
// ----------------------------------------------------------------------------
// mem_request_sequencer
// Front-end for the 8-bit x 256-word memory unit. Core requests are queued in
// a small FIFO. They go to the memory one at a time: the sequencer issues a
// command, waits for mem_ready, and returns one in-order response per request.
// Each command cycle runs IDLE -> WAIT -> RESP -> GAP. The GAP state
// guarantees that mem_en is low for at least one cycle between commands.
//
// Build option:
//   MEM_TIMEOUT_EN - when defined, a watchdog aborts a command that sees no
//                    mem_ready within TIMEOUT_CYCLES cycles of WAIT. The
//                    aborted request answers with rsp_err=1 and rsp_rdata=0.
//                    When undefined, WAIT lasts until mem_ready and rsp_err
//                    is tied to 0.
// ----------------------------------------------------------------------------
module mem_request_sequencer #(
   parameter int WORDSIZE          = 8,
   parameter int MEMORY_ADDR_WIDTH = 8,
   parameter int FIFO_DEPTH        = 4,
   parameter int TIMEOUT_CYCLES    = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   mem_request_sequencer_if.slave      bus,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Elaboration-time sanity checks on the configuration
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("mem_request_sequencer: FIFO_DEPTH must be a power of two >= 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("mem_request_sequencer: TIMEOUT_CYCLES must be >= 1");
   end

   // One queued or in-flight command
   typedef struct packed {
      logic                         op;
      logic [MEMORY_ADDR_WIDTH-1:0] addr;
      logic [WORDSIZE-1:0]          data;
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   // -------------------------------------------------------------------------
   // Request FIFO
   // -------------------------------------------------------------------------
   cmd_t             fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             full, empty, push, pop;
   cmd_t             head;

   // FSM and command/response registers
   state_t              state_q,     state_d;
   cmd_t                cmd_q,       cmd_d;
   logic                mem_en_q,    mem_en_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                rsp_op_q,    rsp_op_d;
   logic [WORDSIZE-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef MEM_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             rsp_err_q, rsp_err_d;
`endif

   assign full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign head  = fifo_mem[rd_ptr_q];

   // The core sees back-pressure whenever the queue is full. It also sees it
   // while reset is held, so that no request is accepted during reset.
   assign bus.req_ready = reset_n & ~full;
   assign push          = bus.req_valid & bus.req_ready;

   // The only pop point is IDLE. This keeps exactly one command in flight.
   assign pop = (state_q == ST_IDLE) & ~empty;

   // Next-state logic for the FIFO pointers and occupancy
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;   // idle, or push and pop together
      endcase
   end

   // FIFO pointer and occupancy registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: state uses non-blocking assignments so that every register samples pre-edge values.
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // FIFO storage: a write into the slot the write pointer selects
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset. The pointers and count decide which entries are valid, so stale contents are never observed.
      if (push) begin
         fifo_mem[wr_ptr_q] <= cmd_t'{op:   bus.req_op,
                                      addr: bus.req_addr,
                                      data: bus.req_wdata};
      end
   end

   // -------------------------------------------------------------------------
   // Command sequencer FSM
   // -------------------------------------------------------------------------

   // Next state plus command/response register updates
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      mem_en_d    = mem_en_q;
      rsp_valid_d = rsp_valid_q;
      rsp_op_d    = rsp_op_q;
      rsp_rdata_d = rsp_rdata_q;
`ifdef MEM_TIMEOUT_EN
      timer_d     = timer_q;
      rsp_err_d   = rsp_err_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               cmd_d    = head;
               mem_en_d = 1'b1;
               state_d  = ST_WAIT;
`ifdef MEM_TIMEOUT_EN
               timer_d  = '0;
`endif
            end
         end

         ST_WAIT: begin
            // The command stays on mem_* unchanged until it completes.
            // On the expiry cycle, mem_ready takes priority over the watchdog.
            if (bus.mem_ready) begin
               rsp_valid_d = 1'b1;
               rsp_op_d    = cmd_q.op;
               rsp_rdata_d = cmd_q.op ? '0 : bus.mem_dataout;
               mem_en_d    = 1'b0;
               state_d     = ST_RESP;
`ifdef MEM_TIMEOUT_EN
               rsp_err_d   = 1'b0;
            end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
               rsp_valid_d = 1'b1;
               rsp_op_d    = cmd_q.op;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               mem_en_d    = 1'b0;
               state_d     = ST_RESP;
            end else begin
               timer_d     = timer_q + 1'b1;
`endif
            end
         end

         ST_RESP: begin
            // The response holds until the core takes it. No new command is
            // issued in the meantime.
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_GAP;
            end
         end

         ST_GAP: begin
            // This cycle keeps mem_en low before the next command.
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state plus command/response registers. The async reset discards the
   // in-flight command and drops mem_en immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         mem_en_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_op_q    <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         mem_en_q    <= mem_en_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_op_q    <= rsp_op_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

`ifdef MEM_TIMEOUT_EN
   // Watchdog counter and abort flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer_q   <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         timer_q   <= timer_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign bus.rsp_err = rsp_err_q;
`else
   assign bus.rsp_err = 1'b0;
`endif

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.mem_en     = mem_en_q;
   assign bus.mem_op     = cmd_q.op;
   assign bus.mem_addr   = cmd_q.addr;
   assign bus.mem_datain = cmd_q.data;

   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_op     = rsp_op_q;
   assign bus.rsp_rdata  = rsp_rdata_q;

   assign busy       = (state_q != ST_IDLE) | ~empty;
   assign fifo_count = count_q;

endmodule

// File: doc/mem_request_sequencer.md
# mem_request_sequencer

Upstream front-end for the 8-bit × 256-word memory unit. It accepts read/write requests from the core over a valid/ready port and queues them in a small FIFO. It issues them one at a time to the memory unit's en/op/addr/datain port and waits for `mem_ready`. It returns one response per request (read data or write acknowledge) over a valid/ready response port, with an optional watchdog abort.

## Interface
- `WORDSIZE`, 8, data word width
- `MEMORY_ADDR_WIDTH`, 8, address width
- `FIFO_DEPTH`, 4, request FIFO entries; power of 2, ≥2
- `TIMEOUT_CYCLES`, 16, watchdog limit in cycles; used only with `MEM_TIMEOUT_EN`
- `clk`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid & req_ready` at a rising edge
- `req_op`  in  1  1 = WR, 0 = RD
- `req_addr`  in  MEMORY_ADDR_WIDTH  target address
- `req_wdata`  in  WORDSIZE  write data; ignored for RD
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready` at a rising edge
- `rsp_op`  out  1  op of the completed request
- `rsp_rdata`  out  WORDSIZE  read data; 0 for WR and for aborted requests
- `rsp_err`  out  1  request aborted by watchdog
- `mem_en`  out  1  memory enable
- `mem_op`  out  1  memory op (1 = WR, 0 = RD)
- `mem_addr`  out  MEMORY_ADDR_WIDTH  memory address
- `mem_datain`  out  WORDSIZE  memory write data
- `mem_dataout`  in  WORDSIZE  memory read data, valid when `mem_ready` = 1
- `mem_ready`  in  1  memory completion
- `busy`  out  1  FSM not in IDLE, or FIFO non-empty
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of queued entries, excluding the in-flight request

## Operation
- FIFO:
  - `req_ready` = !full, combinational; it is 0 while `reset_n` is low.
  - A push when full is not accepted.
  - A push and a pop in the same cycle are both performed, so the count is unchanged.
- FSM states: IDLE, WAIT, RESP, GAP.
  - **IDLE:** if the FIFO is non-empty, pop the head into the command register, set `mem_en`=1 with op/addr/datain from that register, and go to WAIT.
  - **WAIT:** hold `mem_en` and `mem_op`/`mem_addr`/`mem_datain` stable.
    - On a rising edge with `mem_ready`=1: capture `mem_dataout` into `rsp_rdata` (RD) or 0 (WR), set `rsp_err`=0, clear `mem_en`, set `rsp_valid`=1, and go to RESP.
  - **RESP:** hold `rsp_*` stable.
    - On handshake: clear `rsp_valid` and go to GAP.
    - No new memory request is issued while in RESP.
  - **GAP:** one cycle with `mem_en`=0, then go to IDLE. This guarantees an en-low cycle between consecutive commands.
- `mem_ready` is ignored outside WAIT.
- All addresses 0..2^MEMORY_ADDR_WIDTH−1 are forwarded unchanged; no range check is done here.
- Responses return in request order; exactly one response per accepted request.

## Timing
- Reset values (async, immediate on `reset_n` low):
  - All of these are 0: `mem_en`, `mem_op`, `mem_addr`, `mem_datain`, `rsp_valid`, `rsp_op`, `rsp_rdata`, `rsp_err`, `busy`, `fifo_count`.
  - FSM = IDLE; FIFO pointers = 0.
- Reset mid-operation: the in-flight request and all queued requests are discarded with no response, and `mem_en` drops asynchronously.
- Latency, with FIFO empty and FSM in IDLE:
  - A request accepted at edge k has `mem_en`=1 after edge k+1.
  - If `mem_ready` is sampled high at edge k+1+m (m≥1), `rsp_valid`=1 after that edge.
- Back-to-back throughput with `mem_ready` returning after 1 cycle and `rsp_ready`=1: one request per 4 cycles (IDLE, WAIT, RESP, GAP).
- Capacity while memory is stalled: FIFO_DEPTH queued + 1 in flight.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter clears on WAIT entry and increments every cycle in WAIT.
  - If it reaches TIMEOUT_CYCLES with no `mem_ready`: clear `mem_en`, set `rsp_err`=1 and `rsp_rdata`=0, and go to RESP.
  - A `mem_ready` in the same cycle as expiry wins, giving a normal completion.
- `MEM_TIMEOUT_EN` undefined:
  - WAIT lasts indefinitely.
  - `rsp_err` is tied to 0, and no counter logic is present.

## Test plan
- Issue WR addr 0x10 data 0xA5, then RD addr 0x10, with a memory model returning `mem_ready` 2 cycles after en → two responses in order: (op=1, rdata=0x00, err=0), then (op=0, rdata=0xA5, err=0); `mem_en` is low for ≥1 cycle between them.
- Hold `mem_ready`=0 and offer 7 back-to-back requests → exactly FIFO_DEPTH+1=5 accepted, `req_ready`=0, `fifo_count`=4, `busy`=1.
- Hold `rsp_ready`=0 for 10 cycles after a RD completes with 0x3C → `rsp_valid` stays 1, `rsp_rdata` stays 0x3C, and `mem_en` stays 0 despite a queued request.
- With `MEM_TIMEOUT_EN` and TIMEOUT_CYCLES=16, `mem_ready` never asserted → after 16 WAIT cycles: `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0x00, `mem_en`=0. Without the macro: still in WAIT with `mem_en`=1 after 100 cycles.
- Pull `reset_n` low mid-WAIT with 3 requests queued → `mem_en`, `busy`, `fifo_count` and `rsp_valid` go to 0 immediately; after release, a new RD addr 0x01 completes normally.
- With the FIFO holding 2 entries, push and pop in the same cycle → `fifo_count` stays 2, and responses come back in original order.
